// File: rtl/multi_pkg.sv
// Shared definitions for the multi-cycle unit issue controller.
//   MULTI_W          : operand/result width of the compute unit
//   DEFAULT_DEPTH    : default result FIFO depth (power of two, >= 2)
//   DEFAULT_TIMEOUT  : default completion timeout in WAIT cycles (1..255)
//   OPS_W            : width of the completed-op counter
//   issue_state_t    : issue FSM states
package multi_pkg;

  localparam int MULTI_W         = 64;
  localparam int DEFAULT_DEPTH   = 2;
  localparam int DEFAULT_TIMEOUT = 15;
  localparam int OPS_W           = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ERROR = 2'd3
  } issue_state_t;

endpackage

// File: rtl/multi_issue_ctrl_if.sv
// Stream and unit-side signal bundle for multi_issue_ctrl.
//   in_*   : operand stream (valid/ready) into the controller
//   unit_* : start/operand towards the unit, done/result back from it
//   out_*  : result stream (valid/ready) out of the controller
// Modports: slave = the controller, master = its environment.
interface multi_issue_if;
  import multi_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [MULTI_W-1:0] in_data;
  logic               unit_start;
  logic [MULTI_W-1:0] unit_inp;
  logic               unit_done;
  logic [MULTI_W-1:0] unit_out;
  logic               out_valid;
  logic               out_ready;
  logic [MULTI_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, unit_done, unit_out, out_ready,
    output in_ready, unit_start, unit_inp, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, unit_done, unit_out, out_ready,
    input  in_ready, unit_start, unit_inp, out_valid, out_data
  );

endinterface

// File: rtl/multi_result_fifo.sv
// Synchronous result FIFO, registered write, no bypass.
//   clock, reset : posedge clock, synchronous active-high reset
//   push/push_data : write request; caller guarantees it never overflows
//   pop/pop_data   : read request / head entry (valid while !empty)
//   full, empty, count : occupancy status
module multi_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             rd_en;

  assign rd_en = pop && (count_q != '0);

  // NOTE: storage has no reset; only pointers and count need a defined value,
  // and a reset on the array would cost a reset net to every bit for nothing.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/multi_issue_ctrl.sv
// Issue controller for the fixed-latency 64-bit compute unit.
// Accepts one operand at a time, pulses unit_start, waits for unit_done,
// queues the result and streams it out. An operand is only accepted when the
// result FIFO has a free slot, so a completing op can always be stored.
//   clock, reset  : posedge clock, synchronous active-high reset
//   bus (slave)   : operand stream, unit handshake, result stream
//   err_timeout   : sticky, unit did not answer within TIMEOUT WAIT cycles
//   err_spurious  : sticky, unit_done seen while no op was waiting for it
//   ops_done      : completed-op counter, wraps modulo 2^16
module multi_issue_ctrl
  import multi_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  multi_issue_if.slave     bus,
  output logic             err_timeout,
  output logic             err_spurious,
  output logic [OPS_W-1:0] ops_done
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT);

  issue_state_t       state_q;
  logic [MULTI_W-1:0] unit_inp_q;
  logic               unit_start_q;
  logic               in_ready_q;
  logic               err_timeout_q;
  logic               err_spurious_q;
  logic [7:0]         wait_cnt_q;
  logic [OPS_W-1:0]   ops_done_q;

  logic               accept, done_ok, timeout_hit;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count, fifo_count_d;
  logic [MULTI_W-1:0] fifo_rd_data;

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    accept      = (state_q == IDLE) && in_ready_q && bus.in_valid;
    done_ok     = (state_q == WAIT) && bus.unit_done;
    // Done in the same cycle as expiry takes priority over the timeout.
    timeout_hit = (state_q == WAIT) && !bus.unit_done && (wait_cnt_q + 8'd1 == TIMEOUT_C);
    fifo_pop    = !fifo_empty && bus.out_ready;
    fifo_push   = done_ok && (!fifo_full || fifo_pop);
    // Occupancy after this edge; in_ready for the next cycle is derived from it
    // so it is a pure register and never follows in_valid/out_ready combinationally.
    fifo_count_d = fifo_count;
    if (fifo_push && !fifo_pop)      fifo_count_d = fifo_count + CW'(1);
    else if (!fifo_push && fifo_pop) fifo_count_d = fifo_count - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      unit_inp_q     <= '0;
      unit_start_q   <= 1'b0;
      in_ready_q     <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
      wait_cnt_q     <= '0;
      ops_done_q     <= '0;
    end else begin
      unit_start_q <= 1'b0;
      in_ready_q   <= 1'b0;
      if (bus.unit_done && (state_q != WAIT)) err_spurious_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (accept) begin
            unit_inp_q   <= bus.in_data;
            unit_start_q <= 1'b1;
            state_q      <= ISSUE;
          end else begin
            in_ready_q <= (fifo_count_d < DEPTH_C);
          end
        end
        ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          if (done_ok) begin
            ops_done_q <= ops_done_q + 16'd1;
            in_ready_q <= (fifo_count_d < DEPTH_C);
            state_q    <= IDLE;
          end else if (timeout_hit) begin
            err_timeout_q <= 1'b1;
            state_q       <= ERROR;
          end
        end
        ERROR: begin
          // Terminal until reset; the FIFO keeps draining on its own.
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  multi_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MULTI_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.unit_out),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.unit_start = unit_start_q;
  assign bus.unit_inp   = unit_inp_q;
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_data   = fifo_rd_data;
  assign err_timeout    = err_timeout_q;
  assign err_spurious   = err_spurious_q;
  assign ops_done       = ops_done_q;

endmodule
